inst_fetch_aligner: RTL

Fetch-side front end sitting directly upstream of the instruction decoder. It issues word-aligned fetch requests to the instruction cache and buffers the returned halfwords. It realigns the halfword stream so that mixed 16-bit (RVC) and 32-bit instructions come out one per cycle as inst/inst_length/inst_pc. On a redirect from branch resolution or jalr it flushes the buffer and any in-flight fetch.

---
 rtl/inst_fetch_aligner_pkg.sv | 18 +
 rtl/inst_fetch_aligner_halfword_queue.sv | 56 +++++
 rtl/inst_fetch_aligner.sv | 136 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_aligner_pkg.sv
// Shared types and constants for the fetch aligner.
// Fetch FSM states, halfword type and RVC length marker.
package inst_fetch_aligner_pkg;

  localparam int HW_W = 16;

  localparam logic [1:0] RVC_FULL_LEN = 2'b11;

  typedef logic [HW_W-1:0] hw_t;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_aligner_halfword_queue.sv
// Four-entry halfword shift buffer for the fetch aligner.
// Pops from the head and appends at the post-pop tail in one cycle.
module inst_halfword_queue
  import inst_fetch_aligner_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic [1:0] pop_i,
  input  logic [1:0] push_i,
  input  hw_t        push_lo_i,
  input  hw_t        push_hi_i,
  output hw_t        hw0_o,
  output hw_t        hw1_o,
  output logic [2:0] cnt_o
);

  logic [3:0][HW_W-1:0] hw_q, hw_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           rem;

  // Shift out consumed entries, then append new ones behind what is left.
  always_comb begin
    rem   = cnt_q - {1'b0, pop_i};
    hw_d  = hw_q >> {pop_i, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      if (push_i != 2'd0 && rem == 3'(i)) begin
        hw_d[i] = push_lo_i;
      end
      if (push_i == 2'd2 && rem + 3'd1 == 3'(i)) begin
        hw_d[i] = push_hi_i;
      end
    end
    cnt_d = rem + {1'b0, push_i};
    if (flush_i) begin
      hw_d  = '0;
      cnt_d = '0;
    end
  end

  // Buffer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_q  <= '0;
      cnt_q <= '0;
    end else begin
      hw_q  <= hw_d;
      cnt_q <= cnt_d;
    end
  end

  assign hw0_o = hw_q[0];
  assign hw1_o = hw_q[1];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/inst_fetch_aligner.sv
// Fetch front end: word fetch, halfword buffering and realignment
// of mixed 16/32-bit instructions toward the decoder.
module inst_fetch_aligner
  import inst_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        inst_length,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] RST_HEAD  = {RESET_PC[31:1], 1'b0};
  localparam logic [31:0] RST_FETCH = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q;
  logic         req_q;
  logic [31:0]  head_pc_q;
  logic [31:0]  fetch_addr_q;
  logic         skip_q;

  hw_t          hw0, hw1;
  hw_t          push_lo;
  logic [2:0]   cnt, cnt_rem;
  logic [1:0]   pop, push;
  logic         consume, rsp_take;

  // Decode the head of the buffer into one complete instruction.
  always_comb begin
    inst_valid  = 1'b0;
    inst        = '0;
    inst_length = 1'b0;
    if (hw0[1:0] != RVC_FULL_LEN) begin
      if (cnt != 3'd0) begin
        inst_valid = 1'b1;
        inst       = {16'h0000, hw0};
      end
    end else if (cnt >= 3'd2) begin
      inst_valid  = 1'b1;
      inst        = {hw1, hw0};
      inst_length = 1'b1;
    end
  end

  assign consume  = inst_valid & inst_ready;
  assign pop      = consume ? (inst_length ? 2'd2 : 2'd1) : 2'd0;
  assign cnt_rem  = cnt - {1'b0, pop};
  assign rsp_take = (state_q == FETCH_WAIT) & mem_rsp_valid
                  & ~redirect_valid;
  assign push     = rsp_take ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign push_lo  = skip_q ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

  inst_halfword_queue u_hwq (
    .clk_i     (clk_in),
    .rst_ni    (rst_n_in),
    .flush_i   (redirect_valid),
    .pop_i     (pop),
    .push_i    (push),
    .push_lo_i (push_lo),
    .push_hi_i (mem_rsp_data[31:16]),
    .hw0_o     (hw0),
    .hw1_o     (hw1),
    .cnt_o     (cnt)
  );

  // Fetch FSM; a response arriving with the redirect retires the
  // outstanding request, so no drain is needed in that case.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= FETCH_IDLE;
      req_q        <= 1'b0;
      head_pc_q    <= RST_HEAD;
      fetch_addr_q <= RST_FETCH;
      skip_q       <= RESET_PC[1];
    end else if (redirect_valid) begin
      head_pc_q    <= redirect_pc & ~32'd1;
      fetch_addr_q <= redirect_pc & ~32'd3;
      skip_q       <= redirect_pc[1];
      if ((state_q == FETCH_WAIT || state_q == FETCH_DRAIN)
          && !mem_rsp_valid) begin
        state_q <= FETCH_DRAIN;
        req_q   <= 1'b0;
      end else begin
        state_q <= FETCH_REQ;
        req_q   <= 1'b1;
      end
    end else begin
      if (consume) begin
        head_pc_q <= head_pc_q + (inst_length ? 32'd4 : 32'd2);
      end
      unique case (state_q)
        FETCH_IDLE: begin
          if (cnt_rem <= 3'd2) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b1;
          end
        end
        FETCH_REQ: begin
          if (mem_req_ready) begin
            state_q      <= FETCH_WAIT;
            req_q        <= 1'b0;
            fetch_addr_q <= fetch_addr_q + 32'd4;
          end
        end
        FETCH_WAIT: begin
          if (mem_rsp_valid) begin
            state_q <= FETCH_IDLE;
            skip_q  <= 1'b0;
          end
        end
        FETCH_DRAIN: begin
          if (mem_rsp_valid) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign mem_req_valid = req_q;
  assign mem_req_addr  = fetch_addr_q;
  assign inst_pc       = head_pc_q;

endmodule
